// File: rtl/vedic_seq_16x16.sv
// rtl/vedic_seq_16x16.sv - sequential 16x16 unsigned multiplier time-sharing one vedic 8x8 core over four steps
// Also holds the vedic 2x2/4x4/8x8 combinational building blocks.

module vedic_2x2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] p
);
   logic c1;
   assign c1   = a[1] & b[0] & a[0] & b[1];
   assign p[0] = a[0] & b[0];
   assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
   assign p[2] = (a[1] & b[1]) ^ c1;
   assign p[3] = a[1] & b[1] & c1;
endmodule

module vedic_4x4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);
   logic [3:0] q0, q1, q2, q3;
   vedic_2x2 u_q0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
   vedic_2x2 u_q1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
   vedic_2x2 u_q2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
   vedic_2x2 u_q3 (.a(a[3:2]), .b(b[3:2]), .p(q3));
   assign p = {4'h0, q0} + {2'h0, q1, 2'h0} + {2'h0, q2, 2'h0} + {q3, 4'h0};
endmodule

module vedic_8X8 (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);
   logic [7:0] q0, q1, q2, q3;
   vedic_4x4 u_q0 (.a(a[3:0]), .b(b[3:0]), .p(q0));
   vedic_4x4 u_q1 (.a(a[7:4]), .b(b[3:0]), .p(q1));
   vedic_4x4 u_q2 (.a(a[3:0]), .b(b[7:4]), .p(q2));
   vedic_4x4 u_q3 (.a(a[7:4]), .b(b[7:4]), .p(q3));
   assign p = {8'h0, q0} + {4'h0, q1, 4'h0} + {4'h0, q2, 4'h0} + {q3, 8'h0};
endmodule

module vedic_seq_16x16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] p,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [1:0]  step_q, step_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] p_q, p_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;

   logic [7:0]  op_a, op_b;
   logic [15:0] pp;
   logic [31:0] pp_shift;

   // step[0] selects the high byte of a, step[1] the high byte of b
   assign op_a = step_q[0] ? a_q[15:8] : a_q[7:0];
   assign op_b = step_q[1] ? b_q[15:8] : b_q[7:0];

   vedic_8X8 u_core (.a(op_a), .b(op_b), .p(pp));

   always_comb begin
      pp_shift = {16'h0, pp};
      case (step_q)
         2'd0:    pp_shift = {16'h0, pp};
         2'd3:    pp_shift = {pp, 16'h0};
         default: pp_shift = {8'h0, pp, 8'h0};
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         step_q  <= 2'd0;
         acc_q   <= 32'h0;
         p_q     <= 32'h0;
         a_q     <= 16'h0;
         b_q     <= 16'h0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         acc_q   <= acc_d;
         p_q     <= p_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      acc_d   = acc_q;
      p_d     = p_q;
      a_d     = a_q;
      b_d     = b_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               acc_d   = 32'h0;
               step_d  = 2'd0;
               state_d = MUL;
            end
         end
         MUL: begin
            acc_d  = acc_q + pp_shift;
            step_d = step_q + 2'd1;
            if (step_q == 2'd3) begin
               p_d     = acc_q + pp_shift;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q == MUL) || (state_q == DONE);
      p         = p_q;
   end
endmodule

// File: tb/tb_vedic_seq_16x16.sv
// tb/tb_vedic_seq_16x16.sv - scoreboard bench for vedic_seq_16x16

module tb_vedic_seq_16x16;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] p;
   logic        busy;

   int n_total = 0;
   int n_bad   = 0;
   int n_push  = 0;
   int n_pop   = 0;
   logic [31:0] sb[$];

   vedic_seq_16x16 dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .p(p), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with inputs settled; resolves handshakes of the coming edge.
   task automatic tick();
      logic [31:0] e;
      if (!rst) begin
         if (in_valid && in_ready) begin
            sb.push_back(32'(a) * 32'(b));
            n_push++;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_under", {31'h0, out_valid}, 32'h0);
            else begin
               e = sb.pop_front();
               chk("prod", p, e);
               n_pop++;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic run_op(input logic [15:0] ea, input logic [15:0] eb,
                         input int hold, input bit wild, input bit ordy);
      int lat;
      logic [31:0] exp;
      exp = 32'(ea) * 32'(eb);
      a = ea; b = eb; in_valid = 1'b1; out_ready = ordy;
      tick();
      if (!wild) in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 10) begin
         if (wild) begin
            a = 16'($urandom);
            b = 16'($urandom);
            chk("busy_rdy", {31'h0, in_ready}, 32'h0);
         end
         tick();
         lat++;
      end
      in_valid = 1'b0;
      chk("lat", lat, 4);
      for (int i = 0; i < hold; i++) begin
         chk("hold_v", {31'h0, out_valid}, 32'h1);
         chk("hold_p", p, exp);
         tick();
      end
      out_ready = 1'b1;
      chk("dn_v", {31'h0, out_valid}, 32'h1);
      tick();
      chk("one_cyc", {31'h0, out_valid}, 32'h0);
      chk("idle_rdy", {31'h0, in_ready}, 32'h1);
      out_ready = 1'b0;
   endtask

   initial begin
      int cyc, push0, pop0;
      logic [31:0] junk;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_rdy",  {31'h0, in_ready},  32'h1);
      chk("rst_ov",   {31'h0, out_valid}, 32'h0);
      chk("rst_busy", {31'h0, busy},      32'h0);
      chk("rst_p",    p,                  32'h0);
      rst = 1'b0;

      run_op(16'h1234, 16'h5678, 0, 1'b0, 1'b1);
      chk("p_1234", p, 32'h06260060);
      run_op(16'hFFFF, 16'hFFFF, 0, 1'b0, 1'b1);
      chk("p_ffff", p, 32'hFFFE0001);
      run_op(16'h0000, 16'hABCD, 0, 1'b0, 1'b0);
      chk("p_zero", p, 32'h0);
      run_op(16'h00FF, 16'h0100, 10, 1'b0, 1'b0);
      run_op(16'hBEEF, 16'h1357, 0, 1'b1, 1'b1);

      // reset during step2 abandons the operation
      a = 16'h4321; b = 16'h8765; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("ab_rdy",  {31'h0, in_ready},  32'h1);
      chk("ab_ov",   {31'h0, out_valid}, 32'h0);
      chk("ab_p",    p,                  32'h0);
      chk("ab_busy", {31'h0, busy},      32'h0);
      if (sb.size() > 0) junk = sb.pop_front();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("ab_none", {31'h0, out_valid}, 32'h0);

      // accept coinciding with reset is discarded
      in_valid = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("rac_rdy",  {31'h0, in_ready}, 32'h1);
      chk("rac_busy", {31'h0, busy},     32'h0);

      // back-to-back random stream
      push0 = n_push; pop0 = n_pop; cyc = 0;
      while ((n_pop - pop0) < 100 && cyc < 3000) begin
         in_valid  = (n_push - push0) < 100;
         a         = 16'($urandom);
         b         = 16'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         tick();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("stream_cnt", n_pop - pop0, 100);
      chk("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
